// File: rtl/datapath_bus_keeper_if.sv
// Bus-keeper handshake bundle: gate selects and source data in,
// keeper bus value plus contention/error status out.
interface datapath_bus_keeper_if #(
   parameter int WIDTH = 16,
   parameter int NSRC  = 4,
   parameter int CNT_W = 8
);
   localparam int SRC_W = $clog2(NSRC);

   logic [NSRC*WIDTH-1:0] src_data;
   logic [NSRC-1:0]       select_1hot;
   logic                  err_clr;
   logic [WIDTH-1:0]      bus_out;
   logic                  bus_driven;
   logic                  conflict;
   logic                  err_sticky;
   logic [CNT_W-1:0]      err_count;
   logic [SRC_W-1:0]      last_src;
   logic [WIDTH-1:0]      keeper_q;

   modport master (
      output src_data, select_1hot, err_clr,
      input  bus_out, bus_driven, conflict,
      input  err_sticky, err_count, last_src, keeper_q
   );

   modport slave (
      input  src_data, select_1hot, err_clr,
      output bus_out, bus_driven, conflict,
      output err_sticky, err_count, last_src, keeper_q
   );
endinterface

// File: rtl/datapath_bus_keeper.sv
// Shared datapath bus driver with keeper, one-hot contention
// detection, sticky error flag and saturating conflict counter.
module datapath_bus_keeper #(
   parameter int WIDTH = 16,
   parameter int NSRC  = 4,
   parameter int CNT_W = 8
) (
   input logic                  Clk,
   input logic                  Reset,
   datapath_bus_keeper_if.slave bus
);
   localparam int SRC_W = $clog2(NSRC);
   localparam int PC_W  = SRC_W + 1;

   logic [PC_W-1:0]  pop;
   logic [SRC_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_val;
   logic             driven;
   logic             clash;

   logic [WIDTH-1:0] keep_q;
   logic [SRC_W-1:0] last_q;
   logic             sticky_q;
   logic [CNT_W-1:0] cnt_q;

   // Count asserted gates; on a legal drive the last hit is the only hit.
   always_comb begin
      pop     = '0;
      sel_idx = '0;
      sel_val = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (bus.select_1hot[i]) begin
            pop     = pop + PC_W'(1);
            sel_idx = SRC_W'(i);
            sel_val = bus.src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Anything that is neither exactly one gate nor no gate is contention,
   // so the bus falls back to the kept value instead of merging sources.
   assign driven = (pop == PC_W'(1));
   assign clash  = !driven && (bus.select_1hot != '0);

   assign bus.bus_out    = driven ? sel_val : keep_q;
   assign bus.bus_driven = driven;
   assign bus.conflict   = clash;
   assign bus.err_sticky = sticky_q;
   assign bus.err_count  = cnt_q;
   assign bus.last_src   = last_q;
   assign bus.keeper_q   = keep_q;

   // Keeper capture and error bookkeeping; reset overrides every update.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         keep_q   <= '0;
         last_q   <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (driven) begin
            keep_q <= sel_val;
            last_q <= sel_idx;
         end
         if (clash) begin
            sticky_q <= 1'b1;
            if (bus.err_clr)
               cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)
               cnt_q <= cnt_q + CNT_W'(1);
         end else if (bus.err_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
         end
      end
   end
endmodule
